// File: rtl/iterative_shifter.sv
// Iterative barrel shifter: one binary-weighted shift stage per clock cycle,
// so every request takes exactly log2(WIDTH) cycles regardless of amount/op.
`timescale 1ns/1ps

module iterative_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Operation encodings as seen on in_op.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Index of the final stage and the full data width at shift-distance width.
  localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);
  localparam logic [SHW:0]   FULL_DIST  = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             alive;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   amt_q;
  logic [1:0]       op_q;
  logic             fill_q;
  logic             accept;
  logic             last_stage;
  logic [SHW:0]     shift_dist;
  logic [WIDTH-1:0] stage_result;

  // Handshake outputs decode directly from the state register; alive keeps
  // in_ready low until the first clock edge after reset has been released.
  assign in_ready   = (state == IDLE) && alive;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready && !flush;
  assign last_stage = (k == LAST_STAGE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Becomes set on the first edge out of reset and stays set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Next-state logic; flush overrides accept, stage progress and handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (last_stage) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (flush) begin
      next_state = IDLE;
    end
  end

  // Apply stage k: shift by 2^k when the matching amount bit is set.
  always_comb begin
    shift_dist   = (SHW+1)'(1) << k;
    stage_result = work;
    if (amt_q[k]) begin
      case (op_q)
        OP_SLL:  stage_result = work << shift_dist;
        OP_SRL:  stage_result = work >> shift_dist;
        OP_SRA:  stage_result = (work >> shift_dist) |
                                ({WIDTH{fill_q}} & ~({WIDTH{1'b1}} >> shift_dist));
        OP_ROR:  stage_result = (work >> shift_dist) |
                                (work << (FULL_DIST - shift_dist));
        default: stage_result = work;
      endcase
    end
  end

  // Capture the request on accept, then step the working register one stage
  // per cycle; the last stage also loads the visible result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k        <= '0;
      work     <= '0;
      amt_q    <= '0;
      op_q     <= OP_SLL;
      fill_q   <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
    end else if (flush) begin
      k <= '0;
    end else if (accept) begin
      work   <= in_data;
      amt_q  <= in_amt;
      op_q   <= in_op;
      fill_q <= (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
      k      <= '0;
    end else if (state == SHIFT) begin
      work <= stage_result;
      if (last_stage) begin
        k        <= '0;
        out_data <= stage_result;
        out_zero <= (stage_result == '0);
      end else begin
        k <= k + SHW'(1);
      end
    end
  end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, data width; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL derive localparam SHW = log2(WIDTH), the shift-amount width and stage count.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, unsigned.
REQ-009 in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 flush  input  1  synchronous abort of any in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  WIDTH  shift result.
REQ-014 out_zero  output  1  high when out_data is all zeros.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-017 On accept, the block SHALL capture in_data into a WIDTH-bit working register, capture in_amt, in_op and the fill bit (in_data[WIDTH-1] for SRA, 0 otherwise), clear stage counter k to 0, and go to SHIFT.
REQ-018 In SHIFT, each cycle the block SHALL apply stage k: if amt[k]=1, shift the working register by 2^k per captured op, else hold it; then k increments.
REQ-019 Stage rules: SLL fills low bits with 0; SRL fills high bits with 0; SRA fills high bits with the captured fill bit; ROR moves the low 2^k bits to the top.
REQ-020 After stage k=SHW-1 the block SHALL go to DONE; latency is fixed at SHW cycles from the accept edge to out_valid=1, independent of amount and op (5 cycles at WIDTH=32).
REQ-021 in_amt=0 SHALL still take SHW cycles and SHALL return in_data unchanged.
REQ-022 In DONE, out_valid SHALL be 1 and out_data/out_zero SHALL hold stable until out_ready=1.
REQ-023 On a DONE edge with out_ready=1, the block SHALL go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-024 out_valid SHALL be 0 in IDLE and SHIFT; out_data SHALL retain its last result outside DONE, and input changes after accept SHALL NOT affect the result.
REQ-025 flush=1 SHALL force IDLE on the next edge from any state and discard the in-flight result, with out_valid=0; flush takes priority over accept and over the out_ready handshake.
REQ-026 out_zero SHALL be registered alongside out_data and be valid whenever out_valid=1.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, k=0, working register 0, out_data=0, out_zero=0, out_valid=0, in_ready=0 while reset_n is low.
REQ-028 Once reset_n is high, in_ready SHALL be 1 from the first clock edge; reset asserted mid-SHIFT or mid-DONE SHALL discard the operation.

Verification
REQ-029 SRA, WIDTH=32: in_data 0x80000000, amt 31 -> out_data 0xFFFFFFFF, out_zero 0, out_valid high exactly 5 cycles after the accept edge.
REQ-030 SRL 0x80000000 amt 4 -> 0x08000000; SLL 0x00000001 amt 31 -> 0x80000000; ROR 0x0000000F amt 4 -> 0xF0000000.
REQ-031 SLL 0x80000000 amt 1 -> 0x00000000, out_zero 1; any op with amt 0 on 0x12345678 -> 0x12345678 after 5 cycles.
REQ-032 Backpressure: out_ready held low 3 cycles in DONE -> out_data stable, in_ready 0; out_ready high -> IDLE, in_ready 1 one cycle later.
REQ-033 Flush in SHIFT cycle 2 -> IDLE next edge, no out_valid pulse; a new request completes correctly. Reset pulse mid-SHIFT -> all outputs 0 immediately, no stale result afterward.
REQ-034 Parameter sweep WIDTH=8 and WIDTH=64: random op/amt/data checked against a reference model, latency 3 and 6 cycles respectively.
